flash_mp_pipe: RTL and testbench
================================

# flash_mp_pipe

Pipelined, parametrised flash memory-protection gate between the flash control FSM and the flash PHY request port. It accepts one operation at a time over a ready/valid handshake and registers the request before any comparison. It then resolves region permissions with lowest-index priority, and either issues the operation downstream and holds it until completion, or terminates it with an error. Error logging is configurable.

## Interface
Parameters:
- MpRegions, 8: number of programmable regions (1–32).
- NumBanks, 2: flash banks. BankW = max(1, $clog2(NumBanks)).
- AllPagesW, 16: page address width.
- ErrCntW, 8: error counter width. Used only with FLASH_MP_PIPE_ERR_LOG_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- region_cfg_i  in  MpRegions*(4+2*AllPagesW)  per-region {en, rd, prog, erase, base[AllPagesW], size[AllPagesW]}. Region 0 occupies the LSBs.
- default_cfg_i  in  3  {rd, prog, erase} permissions applied when no region matches.
- bank_erase_en_i  in  NumBanks  per-bank erase permission.
- req_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  2  0 read, 1 prog, 2 page erase, 3 bank erase.
- req_addr_i  in  AllPagesW  page address.
- req_bk_i  in  BankW  bank.
- addr_ovfl_i  in  1  address overflow.
- flash_req_o  out  1  downstream request.
- flash_op_o  out  2  downstream opcode.
- flash_addr_o  out  AllPagesW  downstream page address.
- flash_bk_o  out  BankW  downstream bank.
- flash_done_i  in  1  downstream completion.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  one-cycle error pulse, coincident with done_o.
- err_addr_o  out  AllPagesW  error address.
- err_bank_o  out  BankW  error bank.
- err_op_o  out  2  error opcode.
- err_cnt_o  out  ErrCntW  error count. Present only with the macro.
- err_clr_i  in  1  error-log clear. Present only with the macro.

## Operation
- FSM states: IDLE, CHECK, ISSUE, DONE, ERR.
- IDLE:
  - req_ready_o=1.
  - On req_i: capture op, addr, bk, ovfl; go to CHECK.
- CHECK: evaluate protection on the captured request using the live config.
  - Region i matches when en=1, base ≤ addr, and addr < base+size. The sum is computed in AllPagesW+1 bits, so there is no wrap.
  - size=0 never matches.
  - The lowest-index match wins. If nothing matches, default_cfg_i applies.
  - Read, prog and page erase require the matching permission bit.
  - Bank erase ignores regions. It requires bank_erase_en_i[bk], with bk < NumBanks.
  - Allowed and ovfl=0 → ISSUE. Otherwise → ERR.
- ISSUE:
  - flash_req_o=1, with op/addr/bk held stable.
  - Config changes have no effect in this state.
  - flash_done_i → DONE.
- DONE: done_o=1 for one cycle; → IDLE.
- ERR:
  - done_o=1 and error_o=1 for one cycle.
  - err_addr_o, err_bank_o and err_op_o load from the captured request.
  - → IDLE.
- flash_done_i outside ISSUE is ignored.
- Reset values: state IDLE; all outputs 0, except req_ready_o=1 in IDLE.

## Timing
- Request accepted in cycle N (req_i & req_ready_o): CHECK in N+1.
- Error path: ERR pulse in N+2. Minimum request spacing is 3 cycles.
- Allowed path: flash_req_o first high in N+2. flash_done_i in cycle M gives done_o in M+1. Next acceptance is possible in M+2.
- flash_req_o is registered. It never depends combinationally on req_i or config.
- Reset asserted mid-ISSUE: flash_req_o=0 from the next edge. No done_o is produced for the aborted operation.

## Configuration
FLASH_MP_PIPE_ERR_LOG_EN
- Defined:
  - err_cnt_o is a saturating counter (stays at all-ones), incremented in ERR.
  - err_addr_o, err_bank_o and err_op_o hold the first error since the last clear.
  - err_clr_i zeroes the count and re-arms first-error capture.
  - Clear in the same cycle as ERR: count=1, and that error is captured.
- Undefined:
  - err_cnt_o and err_clr_i do not exist.
  - The err_* outputs are overwritten by every error (last error).

## Structure
- Package flash_mp_pipe_pkg:
  - flash_op_e (Read/Prog/PageErase/BankErase).
  - mp_region_cfg_t struct.
  - mp_state_e.
  - MpCfgW = 4+2*AllPagesW.
- Sub-module flash_mp_region_sel: combinational region match, priority select and default fallback. Outputs {hit_idx, rd, prog, erase}.

## Test plan
- Region0 {base 0x10, size 0x10, rd}; read addr 0x1F: flash_req_o high at N+2. flash_done_i at M gives done_o at M+1 and error_o=0.
- Same config, read addr 0x20 with default_cfg_i=0: at N+2, done_o=error_o=1 and err_addr_o=0x20. flash_req_o never rises.
- Region0 {0x0, 0x100, rd only} overlapping region1 {0x0, 0x100, rd/prog}; prog addr 0x5 → error (region0 priority).
- base=0xFFF0, size=0x20 with AllPagesW=16; read 0xFFFF → allowed; read 0x0005 → error (no wrap).
- Bank erase bk=1 with bank_erase_en_i=2'b01 → error, err_bank_o=1. With 2'b10 → issued.
- Macro on: 3 errors → err_cnt_o=3 and err_addr_o = first error's address. err_clr_i concurrent with a 4th error → err_cnt_o=1, 4th error captured. Reset mid-ISSUE → flash_req_o=0 next cycle and no done_o.

Source files
------------

// File: rtl/flash_mp_pipe_pkg.sv
// Shared types and helpers for the flash memory-protection pipeline.
// Region records are unpacked into a fixed-width struct independent of AllPagesW.
package flash_mp_pipe_pkg;

    typedef enum logic [1:0] {
        OpRead      = 2'd0,
        OpProg      = 2'd1,
        OpPageErase = 2'd2,
        OpBankErase = 2'd3
    } flash_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StDone,
        StErr
    } mp_state_e;

    localparam int PageWMax = 32;
    localparam int RawW     = 4 + 2 * PageWMax;
    localparam int MpCfgW   = 4 + 2 * 16;

    typedef struct packed {
        logic                en;
        logic                rd;
        logic                prog;
        logic                erase;
        logic [PageWMax-1:0] base;
        logic [PageWMax-1:0] size;
    } mp_region_cfg_t;

    function automatic int mp_cfg_w(input int apw);
        return 4 + 2 * apw;
    endfunction

    // raw holds one right-justified {en, rd, prog, erase, base, size} record
    function automatic mp_region_cfg_t mp_unpack(input logic [RawW-1:0] raw,
                                                 input int apw);
        mp_region_cfg_t c;
        c = '0;
        for (int j = 0; j < PageWMax; j++) begin
            if (j < apw) begin
                c.size[j] = raw[j];
                c.base[j] = raw[apw + j];
            end
        end
        c.erase = raw[2 * apw];
        c.prog  = raw[2 * apw + 1];
        c.rd    = raw[2 * apw + 2];
        c.en    = raw[2 * apw + 3];
        return c;
    endfunction

endpackage

// File: rtl/flash_mp_region_sel.sv
// Combinational region match with lowest-index priority and default fallback.
// o_hit_idx == MpRegions means no region matched.
import flash_mp_pipe_pkg::*;

module flash_mp_region_sel #(
    parameter int  MpRegions = 8,
    parameter int  AllPagesW = 16,
    localparam int CfgW      = mp_cfg_w(AllPagesW),
    localparam int IdxW      = $clog2(MpRegions + 1)
) (
    input  logic [MpRegions*CfgW-1:0] i_region_cfg,
    input  logic [2:0]                i_default_cfg,
    input  logic [AllPagesW-1:0]      i_addr,
    output logic [IdxW-1:0]           o_hit_idx,
    output logic                      o_rd,
    output logic                      o_prog,
    output logic                      o_erase
);

    mp_region_cfg_t      w_rc;
    logic [PageWMax:0]   w_end;
    logic [PageWMax-1:0] w_addr;

    assign w_addr = PageWMax'(i_addr);

    // Walk from the top so the lowest matching index is written last
    always_comb begin
        w_rc      = '0;
        w_end     = '0;
        o_hit_idx = IdxW'(MpRegions);
        {o_rd, o_prog, o_erase} = i_default_cfg;
        for (int i = MpRegions - 1; i >= 0; i--) begin
            w_rc  = mp_unpack(RawW'(i_region_cfg[i*CfgW +: CfgW]), AllPagesW);
            w_end = {1'b0, w_rc.base} + {1'b0, w_rc.size};
            if (w_rc.en && (w_rc.size != '0) &&
                (w_rc.base <= w_addr) && ({1'b0, w_addr} < w_end)) begin
                o_hit_idx = IdxW'(i);
                o_rd      = w_rc.rd;
                o_prog    = w_rc.prog;
                o_erase   = w_rc.erase;
            end
        end
    end

endmodule

// File: rtl/flash_mp_pipe.sv
// Registered memory-protection gate between flash control FSM and PHY port.
// FLASH_MP_PIPE_ERR_LOG_EN adds a saturating error count and first-error log.
import flash_mp_pipe_pkg::*;

module flash_mp_pipe #(
    parameter int  MpRegions = 8,
    parameter int  NumBanks  = 2,
    parameter int  AllPagesW = 16,
    parameter int  ErrCntW   = 8,
    localparam int BankW     = (NumBanks > 1) ? $clog2(NumBanks) : 1,
    localparam int CfgW      = mp_cfg_w(AllPagesW)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [MpRegions*CfgW-1:0] region_cfg_i,
    input  logic [2:0]                default_cfg_i,
    input  logic [NumBanks-1:0]       bank_erase_en_i,
    input  logic                      req_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_op_i,
    input  logic [AllPagesW-1:0]      req_addr_i,
    input  logic [BankW-1:0]          req_bk_i,
    input  logic                      addr_ovfl_i,
    output logic                      flash_req_o,
    output logic [1:0]                flash_op_o,
    output logic [AllPagesW-1:0]      flash_addr_o,
    output logic [BankW-1:0]          flash_bk_o,
    input  logic                      flash_done_i,
    output logic                      done_o,
    output logic                      error_o,
    output logic [AllPagesW-1:0]      err_addr_o,
    output logic [BankW-1:0]          err_bank_o,
    output logic [1:0]                err_op_o
`ifdef FLASH_MP_PIPE_ERR_LOG_EN
    ,
    output logic [ErrCntW-1:0]        err_cnt_o,
    input  logic                      err_clr_i
`endif
);

    mp_state_e                    r_state, w_next;
    flash_op_e                    r_op;
    logic [AllPagesW-1:0]         r_addr;
    logic [BankW-1:0]             r_bk;
    logic                         r_ovfl;
    logic                         r_ready, r_freq, r_done, r_err;
    logic [AllPagesW-1:0]         r_err_addr;
    logic [BankW-1:0]             r_err_bank;
    logic [1:0]                   r_err_op;
    logic                         w_rd, w_prog, w_erase;
    logic                         w_bank_ok, w_allow, w_err_ev;
    logic [$clog2(MpRegions+1)-1:0] w_hit_idx;

    flash_mp_region_sel #(
        .MpRegions (MpRegions),
        .AllPagesW (AllPagesW)
    ) u_region_sel (
        .i_region_cfg  (region_cfg_i),
        .i_default_cfg (default_cfg_i),
        .i_addr        (r_addr),
        .o_hit_idx     (w_hit_idx),
        .o_rd          (w_rd),
        .o_prog        (w_prog),
        .o_erase       (w_erase)
    );

    // Out-of-range banks never match a permission bit
    always_comb begin
        w_bank_ok = 1'b0;
        for (int b = 0; b < NumBanks; b++) begin
            if (r_bk == BankW'(b)) w_bank_ok = bank_erase_en_i[b];
        end
    end

    always_comb begin
        w_allow = 1'b0;
        unique case (r_op)
            OpRead:      w_allow = w_rd;
            OpProg:      w_allow = w_prog;
            OpPageErase: w_allow = w_erase;
            OpBankErase: w_allow = w_bank_ok;
            default:     w_allow = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  if (req_i) w_next = StCheck;
            StCheck: w_next = (w_allow && !r_ovfl) ? StIssue : StErr;
            StIssue: if (flash_done_i) w_next = StDone;
            StDone:  w_next = StIdle;
            StErr:   w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    assign w_err_ev = (r_state == StCheck) && (w_next == StErr);

    // Handshake outputs come straight from flops keyed on the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_freq  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == StIdle);
            r_freq  <= (w_next == StIssue);
            r_done  <= (w_next == StDone) || (w_next == StErr);
            r_err   <= (w_next == StErr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op   <= OpRead;
            r_addr <= '0;
            r_bk   <= '0;
            r_ovfl <= 1'b0;
        end else if ((r_state == StIdle) && req_i) begin
            r_op   <= flash_op_e'(req_op_i);
            r_addr <= req_addr_i;
            r_bk   <= req_bk_i;
            r_ovfl <= addr_ovfl_i;
        end
    end

`ifdef FLASH_MP_PIPE_ERR_LOG_EN
    logic [ErrCntW-1:0] r_err_cnt;
    logic               r_armed;

    // A clear coinciding with an error keeps that error as the first one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt  <= '0;
            r_armed    <= 1'b1;
            r_err_addr <= '0;
            r_err_bank <= '0;
            r_err_op   <= '0;
        end else if (err_clr_i) begin
            if (w_err_ev || (r_state == StErr)) begin
                r_err_cnt  <= ErrCntW'(1);
                r_armed    <= 1'b0;
                r_err_addr <= r_addr;
                r_err_bank <= r_bk;
                r_err_op   <= r_op;
            end else begin
                r_err_cnt <= '0;
                r_armed   <= 1'b1;
            end
        end else if (w_err_ev) begin
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
            if (r_armed) begin
                r_armed    <= 1'b0;
                r_err_addr <= r_addr;
                r_err_bank <= r_bk;
                r_err_op   <= r_op;
            end
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_addr <= '0;
            r_err_bank <= '0;
            r_err_op   <= '0;
        end else if (w_err_ev) begin
            r_err_addr <= r_addr;
            r_err_bank <= r_bk;
            r_err_op   <= r_op;
        end
    end
`endif

    assign req_ready_o  = r_ready;
    assign flash_req_o  = r_freq;
    assign done_o       = r_done;
    assign error_o      = r_err;
    assign flash_op_o   = r_op;
    assign flash_addr_o = r_addr;
    assign flash_bk_o   = r_bk;
    assign err_addr_o   = r_err_addr;
    assign err_bank_o   = r_err_bank;
    assign err_op_o     = r_err_op;

endmodule

// File: tb/tb_flash_mp_pipe.sv
// Directed bench for flash_mp_pipe: cycle-timeline model plus literal checks.
// Covers FLASH_MP_PIPE_ERR_LOG_EN behaviour when that macro is defined.
module tb_flash_mp_pipe;

    localparam int NR    = 8;
    localparam int AW    = 16;
    localparam int CW    = 4 + 2 * AW;
    localparam int Never = 1 << 30;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [NR*CW-1:0] region_cfg_i;
    logic [2:0]      default_cfg_i = '0;
    logic [1:0]      bank_erase_en_i = '0;
    logic            req_i = 1'b0;
    logic            req_ready_o;
    logic [1:0]      req_op_i = '0;
    logic [AW-1:0]   req_addr_i = '0;
    logic            req_bk_i = 1'b0;
    logic            addr_ovfl_i = 1'b0;
    logic            flash_req_o;
    logic [1:0]      flash_op_o;
    logic [AW-1:0]   flash_addr_o;
    logic            flash_bk_o;
    logic            flash_done_i = 1'b0;
    logic            done_o;
    logic            error_o;
    logic [AW-1:0]   err_addr_o;
    logic            err_bank_o;
    logic [1:0]      err_op_o;
`ifdef FLASH_MP_PIPE_ERR_LOG_EN
    logic [7:0]      err_cnt_o;
    logic            err_clr_i = 1'b0;
`endif

    bit            c_en [NR];
    bit            c_rd [NR];
    bit            c_pg [NR];
    bit            c_er [NR];
    logic [AW-1:0] c_base [NR];
    logic [AW-1:0] c_size [NR];

    int checks   = 0;
    int failures = 0;

    flash_mp_pipe dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .region_cfg_i    (region_cfg_i),
        .default_cfg_i   (default_cfg_i),
        .bank_erase_en_i (bank_erase_en_i),
        .req_i           (req_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_addr_i      (req_addr_i),
        .req_bk_i        (req_bk_i),
        .addr_ovfl_i     (addr_ovfl_i),
        .flash_req_o     (flash_req_o),
        .flash_op_o      (flash_op_o),
        .flash_addr_o    (flash_addr_o),
        .flash_bk_o      (flash_bk_o),
        .flash_done_i    (flash_done_i),
        .done_o          (done_o),
        .error_o         (error_o),
        .err_addr_o      (err_addr_o),
        .err_bank_o      (err_bank_o),
        .err_op_o        (err_op_o)
`ifdef FLASH_MP_PIPE_ERR_LOG_EN
        ,
        .err_cnt_o       (err_cnt_o),
        .err_clr_i       (err_clr_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        region_cfg_i = '0;
        for (int i = 0; i < NR; i++)
            region_cfg_i[i*CW +: CW] = {c_en[i], c_rd[i], c_pg[i], c_er[i],
                                        c_base[i], c_size[i]};
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Permission decision straight from the rules: first region hit, else default
    function automatic bit m_allowed(input logic [1:0] op, input logic [AW-1:0] addr,
                                     input logic bk, input bit ovfl);
        int hit;
        logic [2:0] perm;
        hit = -1;
        if (ovfl) return 1'b0;
        if (op == 2'd3) return bank_erase_en_i[bk];
        for (int i = 0; i < NR; i++)
            if (hit < 0 && c_en[i] && int'(addr) >= int'(c_base[i]) &&
                int'(addr) < int'(c_base[i]) + int'(c_size[i]))
                hit = i;
        perm = (hit < 0) ? default_cfg_i : {c_rd[hit], c_pg[hit], c_er[hit]};
        case (op)
            2'd0:    return perm[2];
            2'd1:    return perm[1];
            default: return perm[0];
        endcase
    endfunction

    // Model state: acceptance cycle, end (pulse) cycle, verdict, error log
    int            cyc = 0;
    bit            mv = 1'b0;
    bit            busy = 1'b0;
    bit            m_ok = 1'b0;
    int            t_acc = 0;
    int            t_end = 0;
    logic [1:0]    m_op = '0;
    logic [AW-1:0] m_addr = '0;
    logic          m_bk = 1'b0;
    logic [AW-1:0] m_eaddr = '0;
    logic          m_ebank = 1'b0;
    logic [1:0]    m_eop = '0;
    int            m_cnt = 0;
    bit            m_armed = 1'b1;

    always @(posedge clk_i) begin : model
        bit b, ok, ev, inerr, arm;
        int ta, te, cnt;
        logic [1:0] op, eo;
        logic [AW-1:0] ad, ea;
        logic bk, eb;
        b = busy; ok = m_ok; ta = t_acc; te = t_end;
        op = m_op; ad = m_addr; bk = m_bk;
        ea = m_eaddr; eb = m_ebank; eo = m_eop; cnt = m_cnt; arm = m_armed;
        ev = 1'b0; inerr = 1'b0;
        if (rst_i) begin
            b = 1'b0; ea = '0; eb = 1'b0; eo = '0; cnt = 0; arm = 1'b1;
        end else begin
            if (b && ok && te == Never && flash_done_i && cyc >= ta + 2)
                te = cyc + 1;
            ev    = b && !ok && (cyc == ta + 1);
            inerr = b && !ok && (cyc == ta + 2);
`ifdef FLASH_MP_PIPE_ERR_LOG_EN
            if (err_clr_i) begin
                if (ev || inerr) begin
                    cnt = 1; arm = 1'b0; ea = ad; eb = bk; eo = op;
                end else begin
                    cnt = 0; arm = 1'b1;
                end
            end else if (ev) begin
                if (cnt < 255) cnt++;
                if (arm) begin ea = ad; eb = bk; eo = op; arm = 1'b0; end
            end
`else
            if (ev) begin ea = ad; eb = bk; eo = op; end
`endif
            if (b && cyc == te) b = 1'b0;
            else if (!b && req_i) begin
                b = 1'b1; ta = cyc;
                op = req_op_i; ad = req_addr_i; bk = req_bk_i;
                ok = m_allowed(req_op_i, req_addr_i, req_bk_i, addr_ovfl_i);
                te = ok ? Never : cyc + 2;
            end
        end
        busy <= b; m_ok <= ok; t_acc <= ta; t_end <= te;
        m_op <= op; m_addr <= ad; m_bk <= bk;
        m_eaddr <= ea; m_ebank <= eb; m_eop <= eo; m_cnt <= cnt; m_armed <= arm;
        mv <= 1'b1;
        cyc <= cyc + 1;
    end

    always @(negedge clk_i) begin : compare
        bit e_fr, e_dn;
        if (mv) begin
            e_fr = busy && m_ok && (cyc >= t_acc + 2) && (cyc < t_end);
            e_dn = busy && (cyc == t_end);
            chk("m_ready", req_ready_o, !busy);
            chk("m_freq", flash_req_o, e_fr);
            chk("m_done", done_o, e_dn);
            chk("m_error", error_o, e_dn && !m_ok);
            if (e_fr) begin
                chk("m_fop", flash_op_o, m_op);
                chk("m_faddr", flash_addr_o, m_addr);
                chk("m_fbk", flash_bk_o, m_bk);
            end
            chk("m_eaddr", err_addr_o, m_eaddr);
            chk("m_ebank", err_bank_o, m_ebank);
            chk("m_eop", err_op_o, m_eop);
`ifdef FLASH_MP_PIPE_ERR_LOG_EN
            chk("m_ecnt", err_cnt_o, m_cnt);
`endif
        end
    end

    task automatic clr_cfg();
        for (int i = 0; i < NR; i++) begin
            c_en[i] = 0; c_rd[i] = 0; c_pg[i] = 0; c_er[i] = 0;
            c_base[i] = '0; c_size[i] = '0;
        end
    endtask

    task automatic set_rg(input int i, input int base, input int size,
                          input bit r, input bit p, input bit e);
        c_en[i] = 1; c_rd[i] = r; c_pg[i] = p; c_er[i] = e;
        c_base[i] = AW'(base); c_size[i] = AW'(size);
    endtask

    task automatic send(input int op, input int addr, input int bk, input bit ovfl);
        int n;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=0 required=1 t=%0t", $time);
        end
        req_i = 1'b1; req_op_i = 2'(op); req_addr_i = AW'(addr);
        req_bk_i = 1'(bk); addr_ovfl_i = ovfl;
        @(negedge clk_i);
        req_i = 1'b0; addr_ovfl_i = 1'b0;
    endtask

    task automatic run_ok(input int op, input int addr, input int bk, input int hold);
        send(op, addr, bk, 1'b0);
        @(negedge clk_i);
        chk("req_at_n2", flash_req_o, 1);
        chk("addr_at_n2", flash_addr_o, addr);
        repeat (hold) @(negedge clk_i);
        flash_done_i = 1'b1;
        @(negedge clk_i);
        flash_done_i = 1'b0;
        chk("done_at_m1", done_o, 1);
        chk("noerr_at_m1", error_o, 0);
        @(negedge clk_i);
    endtask

    task automatic run_err(input int op, input int addr, input int bk, input bit ovfl);
        send(op, addr, bk, ovfl);
        @(negedge clk_i);
        chk("errdone_at_n2", done_o, 1);
        chk("err_at_n2", error_o, 1);
        chk("noreq_at_n2", flash_req_o, 0);
`ifndef FLASH_MP_PIPE_ERR_LOG_EN
        chk("err_addr_lit", err_addr_o, addr);
        chk("err_bank_lit", err_bank_o, bk);
        chk("err_op_lit", err_op_o, op);
`endif
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        clr_cfg();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_freq", flash_req_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", error_o, 0);
        chk("rst_eaddr", err_addr_o, 0);

        set_rg(0, 'h10, 'h10, 1, 0, 0);
        run_ok(0, 'h1F, 0, 2);
        run_err(0, 'h20, 0, 0);
        run_ok(0, 'h10, 0, 0);
        run_err(0, 'h0F, 0, 0);

        clr_cfg();
        set_rg(0, 'h0, 'h100, 1, 0, 0);
        set_rg(1, 'h0, 'h100, 1, 1, 0);
        run_err(1, 'h5, 0, 0);
        run_ok(0, 'h5, 0, 1);

        clr_cfg();
        set_rg(0, 'hFFF0, 'h20, 1, 0, 0);
        run_ok(0, 'hFFFF, 1, 1);
        run_err(0, 'h0005, 0, 0);

        clr_cfg();
        bank_erase_en_i = 2'b01;
        run_err(3, 'h40, 1, 0);
        bank_erase_en_i = 2'b10;
        run_ok(3, 'h40, 1, 3);

        default_cfg_i = 3'b110;
        run_ok(1, 'h300, 0, 0);
        run_err(2, 'h300, 1, 0);
        run_err(0, 'h300, 0, 1);
        set_rg(0, 'h300, 'h0, 0, 0, 0);
        run_ok(0, 'h300, 0, 0);

        flash_done_i = 1'b1;
        repeat (2) @(negedge clk_i);
        flash_done_i = 1'b0;
        chk("stray_done", done_o, 0);
        chk("stray_ready", req_ready_o, 1);

        clr_cfg();
        default_cfg_i = 3'b000;
        set_rg(0, 'h50, 'h10, 1, 0, 0);
        send(0, 'h55, 0, 0);
        @(negedge clk_i);
        chk("cfgchg_req", flash_req_o, 1);
        c_en[0] = 0;
        repeat (2) @(negedge clk_i);
        chk("cfgchg_hold", flash_req_o, 1);
        flash_done_i = 1'b1;
        @(negedge clk_i);
        flash_done_i = 1'b0;
        chk("cfgchg_done", done_o, 1);
        chk("cfgchg_noerr", error_o, 0);
        @(negedge clk_i);

        set_rg(0, 'h50, 'h10, 1, 0, 0);
        send(0, 'h52, 0, 0);
        @(negedge clk_i);
        chk("abort_req", flash_req_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("abort_drop", flash_req_o, 0);
        chk("abort_nodone", done_o, 0);
        repeat (3) begin
            @(negedge clk_i);
            chk("abort_quiet", done_o, 0);
        end

`ifdef FLASH_MP_PIPE_ERR_LOG_EN
        clr_cfg();
        run_err(0, 'hA1, 0, 0);
        run_err(0, 'hA2, 1, 0);
        run_err(0, 'hA3, 0, 0);
        chk("log_cnt3", err_cnt_o, 3);
        chk("log_first", err_addr_o, 'hA1);
        send(0, 'hA4, 0, 0);
        @(negedge clk_i);
        chk("log_err4", error_o, 1);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("log_clr_cnt", err_cnt_o, 1);
        chk("log_clr_addr", err_addr_o, 'hA4);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        chk("log_idle_clr", err_cnt_o, 0);
        run_err(0, 'hA5, 0, 0);
        chk("log_rearm", err_addr_o, 'hA5);
`endif

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
